adc_scan_sequencer: RTL and testbench
=====================================

# adc_scan_sequencer

Parametrised, handshaked successor to the fixed 32-channel ADC select mux. Autonomously scans NCH interleaved ADC channels in order. Emits one registered sample per accepted slot, tagged with channel index and end-of-scan marker, over a valid/ready interface to the downstream filter datapath. Supports single-shot and continuous scan modes with a runtime-programmable active channel count.

## Interface
- NCH, 32, number of ADC channels (2..64)
- W, 21, sample width in bits
- CW, $clog2(NCH), channel index width
- clk  in  1  system clock, all logic on rising edge
- GlobalReset_n  in  1  asynchronous, active-low reset
- x_adc_flat  in  NCH*W  channel c sample at bits [c*W +: W]
- num_ch  in  CW+1  active channel count, sampled at start
- mode  in  1  0 = single-shot scan, 1 = continuous, sampled at start
- start  in  1  one-cycle start request
- stop  in  1  request to end continuous scanning
- x_adc  out  W  registered selected sample
- x_adc_ch  out  CW  channel index of x_adc
- x_adc_valid  out  1  output holds an unconsumed sample
- x_adc_last  out  1  x_adc is the final channel of its scan
- x_adc_ready  in  1  downstream accepts sample this cycle
- busy  out  1  sequencer in SCAN state

## Operation
- States: IDLE, SCAN. Reset state IDLE.
- Runtime count: n = num_ch clamped to 1..NCH; 0 → 1, >NCH → NCH. Latched as n_r at start; mode latched as mode_r.
- IDLE:
  - start=1 → ch_r=0, stop_pend=0, go SCAN.
  - start while busy is ignored.
- Output slot free when x_adc_valid=0 or x_adc_ready=1.
- SCAN, each cycle the slot is free:
  - Load x_adc ← x_adc_flat[ch_r*W +: W] and x_adc_ch ← ch_r.
  - Set x_adc_last ← (ch_r==n_r-1) and x_adc_valid ← 1.
  - If ch_r≠n_r-1: ch_r←ch_r+1.
  - Else (scan end): ch_r←0. Stay in SCAN if mode_r=1 and stop_pend=0; otherwise go IDLE.
- Slot not free: output registers, ch_r and state hold (backpressure). The input is re-sampled only when the slot frees, never earlier.
- stop=1 in SCAN sets stop_pend. The current scan completes in full, then the block goes IDLE. stop in IDLE has no effect.
- Valid handshake: in IDLE, or in SCAN with no free slot, x_adc_valid clears on x_adc_ready=1. Otherwise it stays 1.
- The last sample of a scan remains valid after the return to IDLE until accepted.
- Output fields change only on a load, so they stay stable while valid=1 and ready=0.

## Timing
- Reset (async assert, sync-safe deassert by system): state=IDLE, ch_r=0, n_r=1, mode_r=0, stop_pend=0.
- Output reset values: x_adc=0, x_adc_ch=0, x_adc_valid=0, x_adc_last=0, busy=0.
- Reset mid-scan: all outputs return to reset values immediately; any pending sample is dropped.
- busy=1 from the cycle after start is accepted until the cycle after the scan-end load that exits SCAN.
- Latency: first sample is valid 2 cycles after the start cycle (start → SCAN, then load).
- Throughput: with x_adc_ready held 1, one sample per cycle. The continuous wrap from n-1 to 0 inserts no bubble.
- Single-shot: new start accepted the cycle busy=0. Minimum start-to-start spacing is n+1 cycles.
- Sample captured = value of x_adc_flat on the load edge.

## Test plan
- NCH=32, W=21, channel c driven with c*1000, num_ch=32, mode=0, ready=1, start pulse → 32 samples (0,1000,…,31000) on consecutive cycles.
  - x_adc_ch 0..31; x_adc_last only on ch 31; busy falls after last; valid drops next cycle.
- Same setup with mode=1, stop pulsed during the 2nd scan at ch 5 → 3rd scan never starts.
  - Exactly 64 samples; wrap 31→0 gap-free; last asserted at samples 32 and 64.
- num_ch=4, mode=1, ready toggling 1,0,0,1,… → no sample lost or duplicated.
  - Sequence 0,1,2,3,0,…; data and ch stable while ready=0.
- num_ch=0 → single sample from ch 0 with last=1. num_ch=40 → exactly 32 samples.
- Start while busy → ignored, sequence unchanged. GlobalReset_n low at ch 10 → all outputs 0 and busy=0 immediately.
- NCH=8, W=12 instance, num_ch=8 → 8 samples, x_adc_ch 3 bits wide, index wraps 7→0 in continuous mode.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// ADC scan sequencer: steps through NCH interleaved ADC channels and hands one
// registered, channel-tagged sample per free output slot to a valid/ready sink.
module adc_scan_sequencer #(
  parameter int NCH = 32,
  parameter int W   = 21,
  parameter int CW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              GlobalReset_n,
  input  logic [NCH*W-1:0]  x_adc_flat,
  input  logic [CW:0]       num_ch,
  input  logic              mode,
  input  logic              start,
  input  logic              stop,
  output logic [W-1:0]      x_adc,
  output logic [CW-1:0]     x_adc_ch,
  output logic              x_adc_valid,
  output logic              x_adc_last,
  input  logic              x_adc_ready,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [CW:0] NCH_L = (CW+1)'(NCH);
  localparam logic [CW:0] ONE_L = (CW+1)'(1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   ch_reg, ch_next;
  logic [CW:0]     n_reg, n_next;
  logic            mode_reg, mode_next;
  logic            stop_pend_reg, stop_pend_next;

  logic [W-1:0]    data_reg, data_next;
  logic [CW-1:0]   tag_reg, tag_next;
  logic            valid_reg, valid_next;
  logic            last_reg, last_next;

  logic [W-1:0]    ch_data [NCH];
  logic [CW:0]     n_clamped;
  logic [CW:0]     n_minus1;
  logic            at_last;
  logic            slot_free;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
      assign ch_data[gi] = x_adc_flat[gi*W +: W];
    end
  endgenerate

  // Out-of-range requests are folded into 1..NCH so the scan always terminates.
  always_comb begin
    n_clamped = num_ch;
    if (num_ch == '0) begin
      n_clamped = ONE_L;
    end else if (num_ch > NCH_L) begin
      n_clamped = NCH_L;
    end
  end

  assign n_minus1  = n_reg - ONE_L;
  assign at_last   = ({1'b0, ch_reg} == n_minus1);
  assign slot_free = !valid_reg || x_adc_ready;

  always_comb begin
    state_next     = state_reg;
    ch_next        = ch_reg;
    n_next         = n_reg;
    mode_next      = mode_reg;
    stop_pend_next = stop_pend_reg;
    data_next      = data_reg;
    tag_next       = tag_reg;
    last_next      = last_reg;
    // A consumed sample drops valid unless a fresh load below replaces it.
    valid_next     = valid_reg && !x_adc_ready;

    case (state_reg)
      IDLE: begin
        if (start) begin
          ch_next        = '0;
          stop_pend_next = 1'b0;
          n_next         = n_clamped;
          mode_next      = mode;
          state_next     = SCAN;
        end
      end

      SCAN: begin
        if (stop) begin
          stop_pend_next = 1'b1;
        end
        if (slot_free) begin
          data_next  = ch_data[ch_reg];
          tag_next   = ch_reg;
          last_next  = at_last;
          valid_next = 1'b1;
          if (!at_last) begin
            ch_next = ch_reg + CW'(1);
          end else begin
            // Continuous mode wraps straight to channel 0 without a bubble.
            ch_next = '0;
            if (!mode_reg || stop_pend_reg) begin
              state_next = IDLE;
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      state_reg     <= IDLE;
      ch_reg        <= '0;
      n_reg         <= ONE_L;
      mode_reg      <= 1'b0;
      stop_pend_reg <= 1'b0;
      data_reg      <= '0;
      tag_reg       <= '0;
      valid_reg     <= 1'b0;
      last_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ch_reg        <= ch_next;
      n_reg         <= n_next;
      mode_reg      <= mode_next;
      stop_pend_reg <= stop_pend_next;
      data_reg      <= data_next;
      tag_reg       <= tag_next;
      valid_reg     <= valid_next;
      last_reg      <= last_next;
    end
  end

  assign x_adc       = data_reg;
  assign x_adc_ch    = tag_reg;
  assign x_adc_valid = valid_reg;
  assign x_adc_last  = last_reg;
  assign busy        = (state_reg == SCAN);

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: a 32x21 instance and an 8x12 instance.
module tb_adc_scan_sequencer;

  logic          clk = 1'b0;
  logic          GlobalReset_n = 1'b0;

  logic [32*21-1:0] x_adc_flat = '0;
  logic [5:0]    num_ch = '0;
  logic          mode = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [20:0]   x_adc;
  logic [4:0]    x_adc_ch;
  logic          x_adc_valid;
  logic          x_adc_last;
  logic          x_adc_ready = 1'b1;
  logic          busy;

  logic [8*12-1:0] flat8 = '0;
  logic [3:0]    num8 = '0;
  logic          mode8 = 1'b0;
  logic          start8 = 1'b0;
  logic          stop8 = 1'b0;
  logic [11:0]   x8;
  logic [2:0]    ch8;
  logic          valid8;
  logic          last8;
  logic          ready8 = 1'b1;
  logic          busy8;

  int total = 0;
  int bad = 0;
  int cnt;
  int first_cyc;
  int last_cyc;
  logic          hold_v;
  logic [4:0]    held_ch;
  logic [20:0]   held_data;
  logic          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic          found;

  always #5 clk = ~clk;

  adc_scan_sequencer #(.NCH(32), .W(21)) dut (
    .clk(clk), .GlobalReset_n(GlobalReset_n), .x_adc_flat(x_adc_flat),
    .num_ch(num_ch), .mode(mode), .start(start), .stop(stop),
    .x_adc(x_adc), .x_adc_ch(x_adc_ch), .x_adc_valid(x_adc_valid),
    .x_adc_last(x_adc_last), .x_adc_ready(x_adc_ready), .busy(busy)
  );

  adc_scan_sequencer #(.NCH(8), .W(12)) dut8 (
    .clk(clk), .GlobalReset_n(GlobalReset_n), .x_adc_flat(flat8),
    .num_ch(num8), .mode(mode8), .start(start8), .stop(stop8),
    .x_adc(x8), .x_adc_ch(ch8), .x_adc_valid(valid8),
    .x_adc_last(last8), .x_adc_ready(ready8), .busy(busy8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single-shot scan with ready=1; optionally fires a stray start mid-scan.
  task automatic run_single(input string tag, input logic [5:0] nc, input int exp_n,
                            input int restart_at);
    num_ch = nc;
    mode = 1'b0;
    x_adc_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      start = (restart_at >= 0 && cnt == restart_at) ? 1'b1 : 1'b0;
      if (x_adc_valid) begin
        check({tag, "_ch"}, 64'(x_adc_ch), 64'(cnt));
        check({tag, "_data"}, 64'(x_adc), 64'(cnt * 1000));
        check({tag, "_last"}, 64'(x_adc_last), 64'(cnt == exp_n - 1));
        cnt++;
      end
      tick();
    end
    start = 1'b0;
    check({tag, "_count"}, 64'(cnt), 64'(exp_n));
    check({tag, "_busy_end"}, 64'(busy), 64'(0));
  endtask

  initial begin
    for (int c = 0; c < 32; c++) x_adc_flat[c*21 +: 21] = 21'(c * 1000);
    for (int c = 0; c < 8; c++) flat8[c*12 +: 12] = 12'(c * 100);

    // Reset state
    tick();
    check("rst_valid", 64'(x_adc_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_data", 64'(x_adc), 64'(0));
    GlobalReset_n = 1'b1;
    tick();

    // Full single-shot scan: latency, ordering, last, busy, valid drop
    num_ch = 6'd32;
    mode = 1'b0;
    x_adc_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy_rise", 64'(busy), 64'(1));
    check("t1_valid_early", 64'(x_adc_valid), 64'(0));
    for (int i = 0; i < 32; i++) begin
      tick();
      check("t1_valid", 64'(x_adc_valid), 64'(1));
      check("t1_ch", 64'(x_adc_ch), 64'(i));
      check("t1_data", 64'(x_adc), 64'(i * 1000));
      check("t1_last", 64'(x_adc_last), 64'(i == 31));
      check("t1_busy", 64'(busy), 64'(i != 31));
    end
    tick();
    check("t1_valid_drop", 64'(x_adc_valid), 64'(0));

    // Continuous with stop at ch 5 of second scan
    mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    first_cyc = -1;
    last_cyc = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      tick();
      stop = 1'b0;
      if (x_adc_valid) begin
        check("t2_ch", 64'(x_adc_ch), 64'(cnt % 32));
        check("t2_data", 64'(x_adc), 64'((cnt % 32) * 1000));
        check("t2_last", 64'(x_adc_last), 64'((cnt % 32) == 31));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        cnt++;
        if (cnt == 38) stop = 1'b1;
      end
    end
    stop = 1'b0;
    check("t2_count", 64'(cnt), 64'(64));
    check("t2_gapfree", 64'(last_cyc - first_cyc), 64'(63));
    check("t2_busy_end", 64'(busy), 64'(0));

    // num_ch=4 continuous with ready toggling 1,0,0,1
    num_ch = 6'd4;
    mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    hold_v = 1'b0;
    held_ch = '0;
    held_data = '0;
    for (int k = 0; k < 60; k++) begin
      stop = (k == 24) ? 1'b1 : 1'b0;
      x_adc_ready = pat[k % 4];
      if (hold_v) begin
        check("t3_hold_valid", 64'(x_adc_valid), 64'(1));
        check("t3_hold_ch", 64'(x_adc_ch), 64'(held_ch));
        check("t3_hold_data", 64'(x_adc), 64'(held_data));
      end
      hold_v = 1'b0;
      if (x_adc_valid) begin
        if (x_adc_ready) begin
          check("t3_ch", 64'(x_adc_ch), 64'(cnt % 4));
          check("t3_data", 64'(x_adc), 64'((cnt % 4) * 1000));
          check("t3_last", 64'(x_adc_last), 64'((cnt % 4) == 3));
          cnt++;
        end else begin
          hold_v = 1'b1;
          held_ch = x_adc_ch;
          held_data = x_adc;
        end
      end
      tick();
    end
    stop = 1'b0;
    x_adc_ready = 1'b1;
    check("t3_whole_scans", 64'(cnt % 4), 64'(0));
    check("t3_enough", 64'(cnt >= 8), 64'(1));
    check("t3_idle", 64'(busy), 64'(0));
    check("t3_drained", 64'(x_adc_valid), 64'(0));

    // Clamp boundaries and ignored start while busy
    run_single("t4_zero", 6'd0, 1, -1);
    run_single("t4_over", 6'd40, 32, -1);
    run_single("t5_restart", 6'd32, 32, 10);

    // Async reset mid-scan at ch 10
    num_ch = 6'd32;
    mode = 1'b0;
    x_adc_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (x_adc_valid && x_adc_ch == 5'd10) found = 1'b1;
    end
    check("t6_reach_ch10", 64'(found), 64'(1));
    GlobalReset_n = 1'b0;
    #1;
    check("t6_rst_data", 64'(x_adc), 64'(0));
    check("t6_rst_ch", 64'(x_adc_ch), 64'(0));
    check("t6_rst_valid", 64'(x_adc_valid), 64'(0));
    check("t6_rst_last", 64'(x_adc_last), 64'(0));
    check("t6_rst_busy", 64'(busy), 64'(0));
    tick();
    GlobalReset_n = 1'b1;
    tick();
    check("t6_post_valid", 64'(x_adc_valid), 64'(0));

    // NCH=8 instance: continuous wrap 7->0, stop during second scan
    num8 = 4'd8;
    mode8 = 1'b1;
    ready8 = 1'b1;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      stop8 = 1'b0;
      if (valid8) begin
        check("t7_ch", 64'(ch8), 64'(cnt % 8));
        check("t7_data", 64'(x8), 64'((cnt % 8) * 100));
        check("t7_last", 64'(last8), 64'((cnt % 8) == 7));
        cnt++;
        if (cnt == 11) stop8 = 1'b1;
      end
    end
    stop8 = 1'b0;
    check("t7_count", 64'(cnt), 64'(16));
    check("t7_busy_end", 64'(busy8), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
